// File: rtl/ql_video_fetch_if.sv
// Bundle of control, SDRAM fetch and FIFO consumer signals for ql_video_fetch.
// The slave modport is the fetch block; the master modport is its environment.
interface ql_video_fetch_if;
    logic        membase;
    logic        frame_start;
    logic        line_start;
    logic        video_cycle;
    logic [18:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_din;
    logic        pop;
    logic [15:0] word;
    logic        empty;
    logic [4:0]  level;
    logic        underrun;
    logic        busy;

    modport slave (
        input  membase, frame_start, line_start, video_cycle, mem_din, pop,
        output mem_addr, mem_rd, word, empty, level, underrun, busy
    );

    modport master (
        output membase, frame_start, line_start, video_cycle, mem_din, pop,
        input  mem_addr, mem_rd, word, empty, level, underrun, busy
    );
endinterface

// File: rtl/ql_video_fetch.sv
// QL screen fetcher: reads LINE_WORDS words per line from SDRAM into a small
// first-word fall-through FIFO, reserving a FIFO slot before each bus request.
module ql_video_fetch #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LINE_WORDS = 64,
    parameter int unsigned LINES      = 256
) (
    input logic             clk_video,
    input logic             reset,
    ql_video_fetch_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(LINE_WORDS + 1);
    localparam int unsigned LW = $clog2(LINES + 1);

    typedef enum logic [1:0] {StIdle, StWaitLine, StFetch, StFrameDone} state_e;

    state_e        state_q, state_d;
    logic          vc_q;
    logic          pending_q, pending_d;
    logic [18:0]   addr_q, addr_d;
    logic [WW-1:0] words_q, words_d;
    logic [LW-1:0] lines_q, lines_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   fifo_q [DEPTH];

    logic rise, fall, push, pop_ok, mem_rd, wr_en;

    always_comb begin
        rise   = bus.video_cycle & ~vc_q;
        fall   = ~bus.video_cycle & vc_q;
        // A pending reservation counts as occupied so every push has room.
        mem_rd = (state_q == StFetch) && (words_q != '0) &&
                 (({1'b0, level_q} + 6'(pending_q)) < 6'(DEPTH));
        push   = fall & pending_q;
        pop_ok = bus.pop & (level_q != 5'd0);
        wr_en  = push & ~bus.frame_start;

        state_d    = state_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        words_d    = words_q;
        lines_d    = lines_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        underrun_d = underrun_q;

        if (bus.frame_start) begin
            addr_d     = bus.membase ? 19'h14000 : 19'h10000;
            lines_d    = LW'(LINES);
            words_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = 5'd0;
            pending_d  = 1'b0;
            underrun_d = 1'b0;
            state_d    = StWaitLine;
        end else begin
            if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            if (bus.pop && level_q == 5'd0) underrun_d = 1'b1;
            level_d = level_q + 5'(push) - 5'(pop_ok);
            if (rise && mem_rd) pending_d = 1'b1;
            if (push) begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                pending_d = 1'b0;
                addr_d    = addr_q + 19'd1;
                words_d   = words_q - WW'(1);
            end
            case (state_q)
                StWaitLine: begin
                    if (bus.line_start && lines_q != '0) begin
                        words_d = WW'(LINE_WORDS);
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (push && words_q == WW'(1)) begin
                        lines_d = lines_q - LW'(1);
                        state_d = (lines_q == LW'(1)) ? StFrameDone : StWaitLine;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            state_q    <= StIdle;
            vc_q       <= 1'b0;
            pending_q  <= 1'b0;
            addr_q     <= 19'h10000;
            words_q    <= '0;
            lines_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 5'd0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vc_q       <= bus.video_cycle;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            lines_q    <= lines_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk_video) begin
        if (!reset && wr_en) fifo_q[wr_ptr_q] <= bus.mem_din;
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_rd   = mem_rd;
    assign bus.word     = fifo_q[rd_ptr_q];
    assign bus.empty    = (level_q == 5'd0);
    assign bus.level    = level_q;
    assign bus.underrun = underrun_q;
    assign bus.busy     = (state_q == StFetch);
endmodule

// File: tb/tb_ql_video_fetch.sv
// Directed bench for ql_video_fetch: reset, fill/stall, abort, underrun,
// paced line delivery and a full 256-line frame, all against hand values.
module tb_ql_video_fetch;
    logic clk_video = 1'b0;
    logic reset     = 1'b1;
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   fetches   = 0;

    ql_video_fetch_if vif ();

    ql_video_fetch dut (
        .clk_video (clk_video),
        .reset     (reset),
        .bus       (vif.slave)
    );

    always #5 clk_video = ~clk_video;

    task automatic tick();
        @(posedge clk_video);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus slot: rise cycle, then fall cycle with data valid (optional pop there).
    task automatic slot(input logic [15:0] d, input logic p);
        vif.video_cycle = 1'b1;
        if (vif.mem_rd) fetches++;
        tick();
        vif.video_cycle = 1'b0;
        vif.mem_din     = d;
        vif.pop         = p;
        tick();
        vif.pop = 1'b0;
    endtask

    task automatic pulse_line();
        vif.line_start = 1'b1;
        tick();
        vif.line_start = 1'b0;
    endtask

    task automatic pulse_frame();
        vif.frame_start = 1'b1;
        tick();
        vif.frame_start = 1'b0;
    endtask

    initial begin
        // Reset held with competing inputs active; reset must win.
        vif.membase     = 1'b1;
        vif.frame_start = 1'b1;
        vif.line_start  = 1'b1;
        vif.video_cycle = 1'b0;
        vif.mem_din     = 16'h0;
        vif.pop         = 1'b1;
        tick();
        tick();
        reset           = 1'b0;
        vif.frame_start = 1'b0;
        vif.line_start  = 1'b0;
        vif.pop         = 1'b0;
        vif.membase     = 1'b0;
        check("rst_addr", 32'(vif.mem_addr), 32'h10000);
        check("rst_rd", 32'(vif.mem_rd), 0);
        check("rst_level", 32'(vif.level), 0);
        check("rst_empty", 32'(vif.empty), 1);
        check("rst_underrun", 32'(vif.underrun), 0);
        check("rst_busy", 32'(vif.busy), 0);

        // No fetch before the first frame_start.
        slot(16'hDEAD, 1'b0);
        pulse_line();
        slot(16'hDEAD, 1'b0);
        check("idle_rd", 32'(vif.mem_rd), 0);
        check("idle_level", 32'(vif.level), 0);
        check("idle_addr", 32'(vif.mem_addr), 32'h10000);
        check("idle_busy", 32'(vif.busy), 0);

        // Fill with no consumer: reservation stops requests at DEPTH.
        vif.membase = 1'b1;
        pulse_frame();
        check("f1_addr", 32'(vif.mem_addr), 32'h14000);
        check("f1_wait_rd", 32'(vif.mem_rd), 0);
        pulse_line();
        check("f1_busy", 32'(vif.busy), 1);
        check("f1_rd", 32'(vif.mem_rd), 1);
        for (int i = 0; i < 8; i++) slot(16'hA000 + 16'(i), 1'b0);
        check("fill_level", 32'(vif.level), 8);
        check("fill_rd", 32'(vif.mem_rd), 0);
        check("fill_addr", 32'(vif.mem_addr), 32'h14008);
        slot(16'hBAD0, 1'b0);
        slot(16'hBAD1, 1'b0);
        check("stall_level", 32'(vif.level), 8);
        check("stall_addr", 32'(vif.mem_addr), 32'h14008);
        check("stall_head", 32'(vif.word), 32'hA000);

        // Pop from full, then push and pop on the same edge.
        vif.pop = 1'b1;
        tick();
        vif.pop = 1'b0;
        check("pop_level", 32'(vif.level), 7);
        check("pop_head", 32'(vif.word), 32'hA001);
        slot(16'hA008, 1'b1);
        check("pp_level", 32'(vif.level), 7);
        check("pp_head", 32'(vif.word), 32'hA002);
        check("pp_addr", 32'(vif.mem_addr), 32'h14009);

        // Abort between rise and fall: the late fall is discarded.
        vif.video_cycle = 1'b1;
        tick();
        vif.membase     = 1'b0;
        vif.frame_start = 1'b1;
        tick();
        vif.frame_start = 1'b0;
        vif.video_cycle = 1'b0;
        vif.mem_din     = 16'hBEEF;
        tick();
        check("abort_level", 32'(vif.level), 0);
        check("abort_empty", 32'(vif.empty), 1);
        check("abort_addr", 32'(vif.mem_addr), 32'h10000);
        check("abort_busy", 32'(vif.busy), 0);

        // Underrun: sticky until frame_start.
        vif.pop = 1'b1;
        tick();
        vif.pop = 1'b0;
        check("ur_set", 32'(vif.underrun), 1);
        check("ur_level", 32'(vif.level), 0);
        tick();
        check("ur_sticky", 32'(vif.underrun), 1);
        pulse_frame();
        check("ur_clear", 32'(vif.underrun), 0);

        // One line at a slot and a pop every 8 cycles, in address order.
        pulse_line();
        for (int i = 0; i < 64; i++) begin
            check("line_addr", 32'(vif.mem_addr), 32'h10000 + 32'(i));
            slot(16'h5000 + 16'(i), 1'b0);
            check("line_word", 32'(vif.word), 32'h5000 + 32'(i));
            vif.pop = 1'b1;
            tick();
            vif.pop = 1'b0;
            repeat (5) tick();
        end
        check("line_busy", 32'(vif.busy), 0);
        check("line_rd", 32'(vif.mem_rd), 0);
        check("line_level", 32'(vif.level), 0);
        check("line_underrun", 32'(vif.underrun), 0);
        check("line_addr_end", 32'(vif.mem_addr), 32'h10040);

        // Full frame with full consumption, then FRAME_DONE ignores line_start.
        pulse_frame();
        fetches = 0;
        for (int ln = 0; ln < 256; ln++) begin
            pulse_line();
            for (int w = 0; w < 64; w++) slot({ln[7:0], w[7:0]}, w != 0);
            check("frame_tail", 32'(vif.word), {16'h0, ln[7:0], 8'h3F});
            vif.pop = 1'b1;
            tick();
            vif.pop = 1'b0;
        end
        check("frame_fetches", 32'(fetches), 16384);
        check("frame_addr", 32'(vif.mem_addr), 32'h14000);
        check("frame_busy", 32'(vif.busy), 0);
        check("frame_underrun", 32'(vif.underrun), 0);
        pulse_line();
        check("done_rd", 32'(vif.mem_rd), 0);
        check("done_busy", 32'(vif.busy), 0);
        slot(16'h1234, 1'b0);
        check("done_level", 32'(vif.level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
